// File: rtl/sccb_config_sequencer_pkg.sv
// Shared types and constants for the SCCB configuration sequencer.
package sccb_config_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWaitXfer,
    StDelay,
    StDone,
    StFail
  } seq_state_e;

  localparam logic [7:0] DefEndAddr   = 8'hFF;
  localparam logic [7:0] DefDelayAddr = 8'hFE;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  // Clock cycles per millisecond of embedded delay.
  function automatic int unsigned ms_ticks(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/sccb_config_rom.sv
// Registered-output configuration ROM; each word is {addr, data}, unused words hold the END tag.
module sccb_config_rom #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter logic [DEPTH*(ADDR_W+DATA_W)-1:0] INIT = '1
) (
  input  logic                     clk_i,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output logic [ADDR_W+DATA_W-1:0] rd_word_o
);

  localparam int unsigned W = ADDR_W + DATA_W;

  logic [W-1:0] word_q;

  always_ff @(posedge clk_i) begin
    word_q <= INIT[rd_idx_i * W +: W];
  end

  assign rd_word_o = word_q;

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the configuration ROM and issues each register write to the SCCB master,
// handling delay entries, NACK retries and restart requests.
module sccb_config_sequencer
  import sccb_config_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [ADDR_W-1:0] DELAY_ADDR = ADDR_W'(DefDelayAddr),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DefEndAddr),
  parameter int unsigned IDX_W     = $clog2(DEPTH),
  parameter logic [DEPTH*(ADDR_W+DATA_W)-1:0] ROM_INIT = '1
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              xfer_done,
  input  logic              xfer_nack,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [IDX_W-1:0]  index
);

  localparam int unsigned Ticks = ms_ticks(CLK_HZ);
  localparam int unsigned DlyW  = $clog2(((1 << DATA_W) - 1) * Ticks + 1);
  localparam int unsigned RtyW  = $clog2(MAX_RETRY + 2);

  seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [RtyW-1:0]     retry_q, retry_d;
  logic [DlyW-1:0]     dly_q, dly_d;
  logic                restart_q, restart_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [ADDR_W+DATA_W-1:0] rom_word;
  logic [ADDR_W-1:0]        rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic                     busy_w, pend, advance, finish, fail;

  sccb_config_rom #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .INIT   (ROM_INIT)
  ) u_rom (
    .clk_i     (clk_50),
    .rd_idx_i  (index_q),
    .rd_word_o (rom_word)
  );

  assign rom_addr = rom_word[ADDR_W+DATA_W-1 -: ADDR_W];
  assign rom_data = rom_word[DATA_W-1:0];
  assign busy_w   = !(state_q inside {StIdle, StDone, StFail});
  assign pend     = restart_q | (busy_w & start);

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    retry_d   = retry_q;
    dly_d     = dly_q;
    restart_d = restart_q;
    addr_d    = addr_q;
    data_d    = data_q;
    advance   = 1'b0;
    finish    = 1'b0;
    fail      = 1'b0;

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          index_d   = '0;
          retry_d   = '0;
          restart_d = 1'b0;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (rom_addr == END_ADDR && rom_data == '1) begin
          finish = 1'b1;
        end else if (rom_addr == DELAY_ADDR) begin
          if (rom_data == '0) begin
            advance = 1'b1;
          end else begin
            dly_d   = DlyW'(rom_data) * DlyW'(Ticks);
            state_d = StDelay;
          end
        end else begin
          addr_d  = rom_addr;
          data_d  = rom_data;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ready) state_d = StWaitXfer;
      end
      StWaitXfer: begin
        if (xfer_done) begin
          if (!xfer_nack) begin
            retry_d = '0;
            advance = 1'b1;
          end else if (retry_q < RtyW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = StIssue;
          end else begin
            fail = 1'b1;
          end
        end
      end
      StDelay: begin
        // Leaving on the count of 1 makes the stay exactly data x Ticks cycles.
        if (dly_q <= DlyW'(1)) advance = 1'b1;
        else                   dly_d   = dly_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (index_q == IDX_W'(DEPTH - 1)) begin
        finish = 1'b1;
      end else begin
        index_d = index_q + 1'b1;
        state_d = StFetch;
      end
    end
    if (finish) state_d = StDone;
    if (fail)   state_d = StFail;

    if (busy_w && start) restart_d = 1'b1;
    // A pending restart hijacks the next FETCH entry or the would-be DONE/FAIL.
    if (busy_w && pend && (state_d inside {StFetch, StDone, StFail})) begin
      state_d   = StFetch;
      index_d   = '0;
      retry_d   = '0;
      restart_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      index_q   <= '0;
      retry_q   <= '0;
      dly_q     <= '0;
      restart_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      retry_q   <= retry_d;
      dly_q     <= dly_d;
      restart_q <= restart_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign cmd_valid = (state_q == StIssue);
  assign cmd_addr  = addr_q;
  assign cmd_data  = data_q;
  assign busy      = busy_w;
  assign finished  = (state_q == StDone);
  assign error     = (state_q == StFail);
  assign index     = index_q;

endmodule
